// File: rtl/dmem_access_ctrl_if.sv
// Core-side and RAM-side signal bundle for the data-memory access controller.
// The controller connects through the slave modport; the cores and the RAM
// (or a testbench standing in for them) connect through the master modport.
interface dmem_access_ctrl_if #(
    parameter int NUM_CORES = 4,
    parameter int AW        = 16,
    parameter int DW        = 16
);
    logic [NUM_CORES-1:0]    core_req;
    logic [NUM_CORES-1:0]    core_we;
    logic [NUM_CORES*AW-1:0] core_addr;
    logic [NUM_CORES*DW-1:0] core_wdata;
    logic [NUM_CORES-1:0]    core_ack;
    logic [DW-1:0]           core_rdata;
    logic [NUM_CORES-1:0]    core_err;
    logic [AW-1:0]           mem_addr;
    logic [DW-1:0]           mem_din;
    logic                    mem_wr;
    logic                    mem_rd;
    logic [DW-1:0]           mem_dout;

    modport slave (
        input  core_req, core_we, core_addr, core_wdata, mem_dout,
        output core_ack, core_rdata, core_err, mem_addr, mem_din, mem_wr, mem_rd
    );

    modport master (
        output core_req, core_we, core_addr, core_wdata, mem_dout,
        input  core_ack, core_rdata, core_err, mem_addr, mem_din, mem_wr, mem_rd
    );
endinterface

// File: rtl/dmem_access_ctrl.sv
// Round-robin bus initiator for the single-port data RAM. Serves one core
// load/store at a time: grant in IDLE, one RAM cycle in ACCESS, ack in DONE.
// Optional feature macro: DMEM_ADDR_CHECK_EN -- when defined, grants whose
// address is >= MEM_DEPTH skip the RAM cycle and are acked with core_err set.
// When undefined, core_err stays 0 and every grant performs a RAM access.
//
//  state    | meaning
//  ---------+-------------------------------------------------------------
//  S_IDLE   | waiting for a request; picks next requester from rr_ptr
//  S_ACCESS | one RAM cycle: strobe high, load data captured at its end
//  S_DONE   | ack pulse to the granted core, round-robin pointer advances
module dmem_access_ctrl #(
    parameter int NUM_CORES = 4,
    parameter int AW        = 16,
    parameter int DW        = 16,
    parameter int MEM_DEPTH = 1024
) (
    input  logic              i_clk,
    input  logic              i_rst,
    dmem_access_ctrl_if.slave bus
);
    localparam int PW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

    if (NUM_CORES < 2 || NUM_CORES > 8 || MEM_DEPTH < 1) begin : g_param_check
        $error("dmem_access_ctrl: unsupported NUM_CORES or MEM_DEPTH");
    end

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    state_t               r_state,    w_state_nxt;
    logic [PW-1:0]        r_rr_ptr,   w_rr_ptr_nxt;
    logic [PW-1:0]        r_grant,    w_grant_nxt;
    logic [NUM_CORES-1:0] r_ack,      w_ack_nxt;
    logic [NUM_CORES-1:0] r_err,      w_err_nxt;
    logic [DW-1:0]        r_rdata,    w_rdata_nxt;
    logic [AW-1:0]        r_mem_addr, w_mem_addr_nxt;
    logic [DW-1:0]        r_mem_din,  w_mem_din_nxt;
    logic                 r_mem_wr,   w_mem_wr_nxt;
    logic                 r_mem_rd,   w_mem_rd_nxt;

    logic                 w_any;
    logic [PW-1:0]        w_sel;
    logic [PW:0]          w_idx;
    logic                 w_sel_we;
    logic [AW-1:0]        w_sel_addr;
    logic [DW-1:0]        w_sel_wdata;
    logic [NUM_CORES-1:0] w_sel_onehot;
    logic [NUM_CORES-1:0] w_grant_onehot;
    logic                 w_addr_bad;

    // Round-robin pick: scan offsets from the highest down so the requester
    // closest at/after rr_ptr is the last one written and therefore wins.
    always_comb begin
        w_any = 1'b0;
        w_sel = '0;
        w_idx = '0;
        for (int k = NUM_CORES - 1; k >= 0; k--) begin
            w_idx = {1'b0, r_rr_ptr} + (PW+1)'(k);
            if (w_idx >= (PW+1)'(NUM_CORES)) begin
                w_idx = w_idx - (PW+1)'(NUM_CORES);
            end
            if (bus.core_req[w_idx[PW-1:0]]) begin
                w_any = 1'b1;
                w_sel = w_idx[PW-1:0];
            end
        end
    end

    assign w_sel_we       = bus.core_we[w_sel];
    assign w_sel_addr     = bus.core_addr[int'(w_sel)*AW +: AW];
    assign w_sel_wdata    = bus.core_wdata[int'(w_sel)*DW +: DW];
    assign w_sel_onehot   = NUM_CORES'(1) << w_sel;
    assign w_grant_onehot = NUM_CORES'(1) << r_grant;

`ifdef DMEM_ADDR_CHECK_EN
    assign w_addr_bad = (32'(w_sel_addr) >= 32'(MEM_DEPTH));
`else
    assign w_addr_bad = 1'b0;
`endif

    // Next-state and next-output logic; every output is registered below.
    always_comb begin
        w_state_nxt    = r_state;
        w_rr_ptr_nxt   = r_rr_ptr;
        w_grant_nxt    = r_grant;
        w_ack_nxt      = '0;
        w_err_nxt      = '0;
        w_rdata_nxt    = r_rdata;
        w_mem_addr_nxt = r_mem_addr;
        w_mem_din_nxt  = r_mem_din;
        w_mem_wr_nxt   = 1'b0;
        w_mem_rd_nxt   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_any) begin
                    w_grant_nxt = w_sel;
                    if (w_addr_bad) begin
                        // Out-of-range: no RAM cycle, ack with error next cycle.
                        w_state_nxt = S_DONE;
                        w_ack_nxt   = w_sel_onehot;
                        w_err_nxt   = w_sel_onehot;
                    end else begin
                        w_state_nxt    = S_ACCESS;
                        w_mem_addr_nxt = w_sel_addr;
                        w_mem_din_nxt  = w_sel_wdata;
                        w_mem_wr_nxt   = w_sel_we;
                        w_mem_rd_nxt   = ~w_sel_we;
                    end
                end
            end
            S_ACCESS: begin
                if (r_mem_rd) begin
                    w_rdata_nxt = bus.mem_dout;
                end
                w_ack_nxt   = w_grant_onehot;
                w_state_nxt = S_DONE;
            end
            S_DONE: begin
                w_rr_ptr_nxt = (r_grant == PW'(NUM_CORES - 1)) ? '0 : r_grant + 1'b1;
                w_state_nxt  = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State and output registers; reset aborts any access in flight.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state    <= S_IDLE;
            r_rr_ptr   <= '0;
            r_grant    <= '0;
            r_ack      <= '0;
            r_err      <= '0;
            r_rdata    <= '0;
            r_mem_addr <= '0;
            r_mem_din  <= '0;
            r_mem_wr   <= 1'b0;
            r_mem_rd   <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_rr_ptr   <= w_rr_ptr_nxt;
            r_grant    <= w_grant_nxt;
            r_ack      <= w_ack_nxt;
            r_err      <= w_err_nxt;
            r_rdata    <= w_rdata_nxt;
            r_mem_addr <= w_mem_addr_nxt;
            r_mem_din  <= w_mem_din_nxt;
            r_mem_wr   <= w_mem_wr_nxt;
            r_mem_rd   <= w_mem_rd_nxt;
        end
    end

    assign bus.core_ack   = r_ack;
    assign bus.core_err   = r_err;
    assign bus.core_rdata = r_rdata;
    assign bus.mem_addr   = r_mem_addr;
    assign bus.mem_din    = r_mem_din;
    assign bus.mem_wr     = r_mem_wr;
    assign bus.mem_rd     = r_mem_rd;
endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Bench for dmem_access_ctrl: directed scenarios plus random traffic, with a
// scoreboard of outstanding requests checked by a decoupled ack monitor.
module tb_dmem_access_ctrl;
    localparam int N     = 4;
    localparam int AW    = 16;
    localparam int DW    = 16;
    localparam int DEPTH = 1024;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_vec = 0;
    int   n_mis = 0;
    int   cyc   = 0;

    dmem_access_ctrl_if #(.NUM_CORES(N), .AW(AW), .DW(DW)) bus ();

    dmem_access_ctrl #(.NUM_CORES(N), .AW(AW), .DW(DW), .MEM_DEPTH(DEPTH)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus.slave)
    );

    initial forever #5 clk = ~clk;
    initial forever begin @(posedge clk); cyc++; end

    typedef struct {
        int            core;
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } exp_t;

    exp_t          sb[$];
    int            ack_log[$];
    int            ack_cyc[$];
    int            ack_cnt[N];
    int            drop_cnt[N];
    logic [DW-1:0] ref_mem[int];
    logic [DW-1:0] ram[0:65535];

    function automatic logic [DW-1:0] init_val(input int a);
        return DW'(a * 40503 + 4660);
    endfunction

    function automatic logic [DW-1:0] ref_rd(input int a);
        if (ref_mem.exists(a)) return ref_mem[a];
        return init_val(a);
    endfunction

    function automatic int rr_pick(input logic [N-1:0] reqs, input int ptr);
        for (int k = 0; k < N; k++) if (reqs[(ptr + k) % N]) return (ptr + k) % N;
        return -1;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // RAM model: synchronous write, read data visible while mem_rd is high
    initial begin
        for (int i = 0; i < 65536; i++) ram[i] = init_val(i);
        forever begin
            @(posedge clk);
            if (bus.mem_wr) ram[bus.mem_addr] = bus.mem_din;
        end
    end
    assign bus.mem_dout = bus.mem_rd ? ram[bus.mem_addr] : ~ram[bus.mem_addr];

    // Ack monitor: pops the acked core's request and checks order and data
    initial begin
        logic [N-1:0]  h1, h2;
        logic [DW-1:0] last_rd;
        logic          oor;
        int            rr_m, g, idx, exp_g;
        exp_t          e;
        h1 = '0; h2 = '0; rr_m = 0; last_rd = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                rr_m    = 0;
                last_rd = '0;
            end else begin
                check("rd_wr_overlap", 32'(bus.mem_wr & bus.mem_rd), 0);
                if (bus.core_ack != '0) begin
                    g = -1;
                    for (int k = 0; k < N; k++) if (bus.core_ack[k]) g = k;
                    check("ack_onehot", $countones(bus.core_ack), 1);
                    check("strobe_in_ack", 32'({bus.mem_wr, bus.mem_rd}), 0);
                    idx = -1;
                    foreach (sb[k]) if (sb[k].core == g && idx < 0) idx = k;
                    check("ack_expected", 32'(idx >= 0), 1);
                    if (idx >= 0) begin
                        e = sb[idx];
                        sb.delete(idx);
                        oor = 1'b0;
`ifdef DMEM_ADDR_CHECK_EN
                        oor = (int'(e.addr) >= DEPTH);
`endif
                        exp_g = rr_pick(oor ? h1 : h2, rr_m);
                        check("grant_order", g, exp_g);
                        check("core_err", 32'(bus.core_err), oor ? (32'd1 << g) : 32'd0);
                        if (!e.we && !oor) last_rd = ref_rd(int'(e.addr));
                        check("core_rdata", 32'(bus.core_rdata), 32'(last_rd));
                        if (e.we && !oor) ref_mem[int'(e.addr)] = e.wdata;
                    end
                    rr_m = (g + 1) % N;
                    ack_cnt[g]++;
                    ack_log.push_back(g);
                    ack_cyc.push_back(cyc);
                end
            end
            h2 = h1;
            h1 = bus.core_req;
        end
    end

    // Advance one clock; a core drops its request on the edge ending its ack
    task automatic tick();
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (ack_cnt[i] != drop_cnt[i]) begin
                bus.core_req[i] = 1'b0;
                drop_cnt[i]     = ack_cnt[i];
            end
        end
    endtask

    task automatic issue(input int c, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        exp_t e;
        bus.core_we[c]             = we;
        bus.core_addr[c*AW +: AW]  = a;
        bus.core_wdata[c*DW +: DW] = d;
        bus.core_req[c]            = 1'b1;
        e.core = c; e.we = we; e.addr = a; e.wdata = d;
        sb.push_back(e);
    endtask

    task automatic drain(input int budget);
        int k;
        k = 0;
        while ((sb.size() != 0 || bus.core_req != '0) && k < budget) begin
            tick();
            k++;
        end
        check("drain_outstanding", sb.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1);
    end

    initial begin
        int            base, n_re, c2;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        bus.core_req = '0; bus.core_we = '0; bus.core_addr = '0; bus.core_wdata = '0;
        #2 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ack",   32'(bus.core_ack), 0);
        check("rst_err",   32'(bus.core_err), 0);
        check("rst_rdata", 32'(bus.core_rdata), 0);
        check("rst_wr",    32'(bus.mem_wr), 0);
        check("rst_rd",    32'(bus.mem_rd), 0);
        check("rst_addr",  32'(bus.mem_addr), 0);
        check("rst_din",   32'(bus.mem_din), 0);
        @(negedge clk);
        rst = 1'b0;
        tick();

        // all four cores load at once: served 0,1,2,3, three cycles apart
        base = ack_log.size();
        for (int i = 0; i < N; i++) issue(i, 1'b0, AW'(i), '0);
        drain(40);
        check("all4_count", ack_log.size() - base, 4);
        if (ack_log.size() - base == 4) begin
            for (int i = 0; i < N; i++) check("all4_order", ack_log[base + i], i);
            for (int i = 1; i < N; i++) check("all4_spacing", ack_cyc[base + i] - ack_cyc[base + i - 1], 3);
        end

        // store then load, core 0, address 5
        issue(0, 1'b1, 16'd5, 16'hBEEF);
        tick();
        check("st_wr",   32'(bus.mem_wr), 1);
        check("st_rd",   32'(bus.mem_rd), 0);
        check("st_addr", 32'(bus.mem_addr), 5);
        check("st_din",  32'(bus.mem_din), 32'hBEEF);
        tick();
        check("st_wr_one_cycle", 32'(bus.mem_wr), 0);
        check("st_ack",  32'(bus.core_ack), 1);
        tick();
        issue(0, 1'b0, 16'd5, '0);
        tick();
        check("ld_rd",   32'(bus.mem_rd), 1);
        check("ld_addr", 32'(bus.mem_addr), 5);
        tick();
        check("ld_ack",   32'(bus.core_ack), 1);
        check("ld_rdata", 32'(bus.core_rdata), 32'hBEEF);
        drain(20);

        // fairness: core0 keeps re-requesting, waiting core2 is served next
        base = ack_log.size();
        c2   = ack_cnt[2];
        n_re = 0;
        issue(0, 1'b0, 16'd10, '0);
        tick();
        issue(2, 1'b0, 16'd20, '0);
        for (int t = 0; t < 15 && ack_cnt[2] == c2; t++) begin
            tick();
            if (!bus.core_req[0] && n_re < 4) begin
                issue(0, 1'b0, AW'(11 + n_re), '0);
                n_re++;
            end
        end
        drain(40);
        check("fair_count", 32'(ack_log.size() - base >= 2), 1);
        if (ack_log.size() - base >= 2) begin
            check("fair_first",  ack_log[base], 0);
            check("fair_second", ack_log[base + 1], 2);
        end

        // store from core1 then load from core3, top in-range address
        d = 16'h5A3C;
        issue(1, 1'b1, 16'h03FF, d);
        drain(20);
        issue(3, 1'b0, 16'h03FF, '0);
        drain(20);
        check("xcore_rdata", 32'(bus.core_rdata), 32'(d));

        // first address past the implemented RAM
        issue(0, 1'b0, 16'h0400, '0);
        tick();
`ifdef DMEM_ADDR_CHECK_EN
        check("oor_ack", 32'(bus.core_ack), 1);
        check("oor_err", 32'(bus.core_err), 1);
        check("oor_rd",  32'(bus.mem_rd), 0);
`else
        check("oor_rd",  32'(bus.mem_rd), 1);
        check("oor_ack_early", 32'(bus.core_ack), 0);
        tick();
        check("oor_ack", 32'(bus.core_ack), 1);
        check("oor_err", 32'(bus.core_err), 0);
`endif
        drain(20);

        // reset in the middle of an access
        issue(1, 1'b1, 16'd30, 16'h1111);
        drain(20);
        base = ack_log.size();
        issue(1, 1'b0, 16'd40, '0);
        tick();
        check("mid_rd_before", 32'(bus.mem_rd), 1);
        #2 rst = 1'b1;
        issue(3, 1'b0, 16'd50, '0);
        #1;
        check("mid_rd",   32'(bus.mem_rd), 0);
        check("mid_wr",   32'(bus.mem_wr), 0);
        check("mid_ack",  32'(bus.core_ack), 0);
        check("mid_addr", 32'(bus.mem_addr), 0);
        @(negedge clk);
        #1 rst = 1'b0;
        drain(30);
        check("mid_count", 32'(ack_log.size() - base), 2);
        if (ack_log.size() - base >= 1) check("mid_first_after_rst", ack_log[base], 1);

        // random traffic
        for (int t = 0; t < 400; t++) begin
            tick();
            for (int c = 0; c < N; c++) begin
                if (!bus.core_req[c] && $urandom_range(0, 2) == 0) begin
                    a = ($urandom_range(0, 7) == 0) ? AW'($urandom) : AW'($urandom_range(0, DEPTH - 1));
                    issue(c, 1'($urandom_range(0, 1)), a, DW'($urandom));
                end
            end
        end
        drain(300);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end
endmodule
